// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pipelined_adder_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout, ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry registered between stages.
// Valid/ready handshake with a global stall (advance) and synchronous flush (clr).

module pipelined_adder_stage #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign s   = sum[CHUNK-1:0];
  assign co  = sum[CHUNK];
endmodule

module pipelined_adder #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  pipelined_adder_if.slave    io
);
  localparam int STAGES = WIDTH / CHUNK;

  logic              advance;
  logic              accept;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;

  assign advance     = !vld_pipe[STAGES] || io.out_ready;
  assign io.in_ready = advance && !clr;
  assign accept      = io.in_valid && io.in_ready;
  assign vld_pipe    = {vld_q, accept};

  // clr drops every valid bit even while stalled; data registers keep stale values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_q <= '0;
    else if (clr)     vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Each stage consumes the low slice of its operands and forwards the rest, so the
  // operand registers shrink by CHUNK bits per stage while the result grows by CHUNK.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k*CHUNK;

    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   c_in;
    logic [CHUNK-1:0]       sl;
    logic                   co;
    logic [(k+1)*CHUNK-1:0] s_nxt;
    logic [(k+1)*CHUNK-1:0] s_q;
    logic                   c_q;

    if (k == 0) begin : g_src
      // subtract as A + ~B + ~Cin; B is inverted once, here at capture
      assign a_in  = io.A;
      assign b_in  = io.B ^ {WIDTH{io.sub}};
      assign c_in  = io.Cin ^ io.sub;
      assign s_nxt = sl;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign s_nxt = {sl, g_stage[k-1].s_q};
    end

    pipelined_adder_stage #(.CHUNK(CHUNK)) u_add (
      .a  (a_in[CHUNK-1:0]),
      .b  (b_in[CHUNK-1:0]),
      .ci (c_in),
      .s  (sl),
      .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (advance && vld_pipe[k]) begin
        s_q <= s_nxt;
        c_q <= co;
      end
    end

    if (k < STAGES-1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && vld_pipe[k]) begin
          a_q <= a_in[REM-1:CHUNK];
          b_q <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic v_q;

      // carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      v_q <= 1'b0;
        else if (advance && vld_pipe[k]) v_q <= co ^ (a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ sl[CHUNK-1]);
      end
    end
  end

  assign io.out_valid = vld_pipe[STAGES];
  assign io.S         = g_stage[STAGES-1].s_q;
  assign io.Cout      = g_stage[STAGES-1].c_q;
  assign io.ovf       = g_stage[STAGES-1].g_last.v_q;
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor of the team's ripple-carry adders. Adds or subtracts WIDTH-bit operands in CHUNK-bit slices, one slice per pipeline stage; the carry is registered between stages.
- Accepts one operation per clock under a valid/ready handshake, with a global stall and a synchronous flush.
- Sits between operand sources and the ALU result path wherever the full ripple chain misses timing.

Parameters:
- WIDTH, 12, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 3, bits added per stage.
- STAGES, WIDTH/CHUNK (derived, localparam), pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush: invalidates all in-flight operations.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in in add mode; borrow-in in subtract mode.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- S  output  WIDTH  sum/difference.
- Cout  output  1  carry out of MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n), clock clk.
- Reset values: all stage valid bits 0, so out_valid=0, S=0, Cout=0, ovf=0. in_ready=1 once reset is released. Reset mid-operation discards all in-flight data and produces no output.
- Arithmetic:
  - add: {Cout,S} = A + B + Cin.
  - sub: {Cout,S} = A + ~B + ~Cin, i.e. S = A - B - Cin mod 2^WIDTH.
  - ovf = carry into MSB XOR carry out of MSB.
  - A, B, Cin and sub are captured together at acceptance; later input changes have no effect on that operation.
- Datapath: stage k (k=1..STAGES) adds bits [k*CHUNK-1:(k-1)*CHUNK] using the registered carry from stage k-1; stage 1 uses the effective carry-in. Lower result slices and upper operand slices ride along in the stage registers. Stage STAGES is the output register driving S, Cout and ovf.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - An input is accepted on an edge with in_valid && in_ready.
  - The pipeline moves only on advance (global stall). While stalled, every stage holds and S, Cout, ovf stay stable.
  - A result is consumed on an edge with out_valid && out_ready.
  - Bubbles are not squeezed out. Valid bits shift with the data.
- Latency: an operation accepted at edge n gives out_valid=1 after edge n+STAGES-1. With defaults: accept at edge 0, visible after edge 3. Throughput is 1 per clock when out_ready stays high.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated.
- clr:
  - clr=1 at an edge clears every valid bit. An input offered in that cycle is not accepted: in_ready is forced 0 while clr=1.
  - Data registers may keep stale values. S is only meaningful when out_valid=1.
- Simultaneous consume and accept on the same edge (full pipe, out_ready=1, in_valid=1): both happen, and occupancy stays the same.
- Wrap-around: S is always modulo 2^WIDTH. The carry leaves only through Cout, never into S.

Test Plan:
- Reset: assert rst_n=0 asynchronously with 3 operations in flight -> out_valid=0 immediately; no result appears after release; first new result arrives 4 cycles after acceptance.
- Add boundaries (defaults): A=0xFFF, B=0x001, Cin=0, sub=0 -> S=0x000, Cout=1, ovf=0. A=0x7FF, B=0x001 -> S=0x800, Cout=0, ovf=1. Each appears after edge n+3.
- Subtract: A=0x005, B=0x007, Cin=0, sub=1 -> S=0xFFE, Cout=0, ovf=0. A=0x800, B=0x001, Cin=0 -> S=0x7FF, Cout=1, ovf=1. A=0x010, B=0x004, Cin=1 -> S=0x00B, Cout=1.
- Streaming: 16 back-to-back random operations with out_ready=1 -> 16 in-order results, one per clock, first after edge 3, each matching the reference model.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0; S, Cout and ovf stable; no loss. Release -> remaining results drain in order and in_ready returns to 1 the same cycle.
- Flush: clr=1 for one cycle with 2 operations in flight and in_valid=1 -> no outputs from those operations; the offered input is not accepted; the next accepted operation produces the correct result 4 cycles later.
